// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: in-order queue of {pc, predicted pc}, misprediction
// flush/redirect and BTB training write. Optional statistics counters under BRU_STATS_EN.
module branch_resolve_unit #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_valid,
   output logic        fetch_ready,
   input  logic [63:0] fetch_pc,
   input  logic [63:0] fetch_pred_pc,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_taken,
   input  logic        ex_is_jump,
   input  logic [63:0] ex_target,
   output logic        flush,
   output logic [63:0] redirect_pc,
   output logic        upd_was_taken,
   output logic        upd_jumped,
   output logic [63:0] upd_prev_pc,
   output logic [63:0] upd_branch_pc,
   output logic        underflow
`ifdef BRU_STATS_EN
   ,
   output logic [31:0] stat_resolved,
   output logic [31:0] stat_mispred
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef logic [AW:0] ptr_t;
   typedef enum logic {ST_RUN, ST_DRAIN} state_t;

   state_t      state, state_next;
   ptr_t        wr_ptr, rd_ptr;
   logic [63:0] pc_mem   [DEPTH];
   logic [63:0] pred_mem [DEPTH];

   logic        empty, full, pop, push, mismatch, underflow_evt;
   logic        do_taken, do_jump;
   logic [63:0] head_pc, head_pred, fall_pc, actual_pc, predicted_pc;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_pc   = pc_mem[rd_ptr[AW-1:0]];
   assign head_pred = pred_mem[rd_ptr[AW-1:0]];
   assign fall_pc   = head_pc + 64'd4;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next    = state;
      pop           = 1'b0;
      underflow_evt = 1'b0;
      fetch_ready   = 1'b0;
      push          = 1'b0;
      do_jump       = 1'b0;
      do_taken      = 1'b0;
      actual_pc     = fall_pc;
      predicted_pc  = fall_pc;
      mismatch      = 1'b0;

      case (state)
         ST_RUN: begin
            pop           = ex_valid && !empty;
            underflow_evt = ex_valid && empty;
            fetch_ready   = !full || pop;
            if (pop) begin
               // A set jump flag overrides the branch flags.
               do_jump  = ex_is_jump;
               do_taken = ex_is_branch && ex_taken && !ex_is_jump;
               if (ex_is_jump || (ex_is_branch && ex_taken)) actual_pc = ex_target;
               if (head_pred != 64'd0) predicted_pc = head_pred;
               mismatch = (actual_pc != predicted_pc);
            end
            if (mismatch) state_next = ST_DRAIN;
         end
         ST_DRAIN: state_next = ST_RUN;
         default:  state_next = ST_RUN;
      endcase

      push = fetch_valid && fetch_ready;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_RUN;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state <= state_next;
         if (mismatch) begin
            // Misprediction discards every younger instruction, including this cycle's push.
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
         end
      end
   end

   // NOTE: queue storage is deliberately not reset; the pointers alone define valid entries.
   always_ff @(posedge clk) begin
      if (push && !mismatch) begin
         pc_mem[wr_ptr[AW-1:0]]   <= fetch_pc;
         pred_mem[wr_ptr[AW-1:0]] <= fetch_pred_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush         <= 1'b0;
         redirect_pc   <= '0;
         upd_was_taken <= 1'b0;
         upd_jumped    <= 1'b0;
         upd_prev_pc   <= '0;
         upd_branch_pc <= '0;
         underflow     <= 1'b0;
      end else begin
         flush         <= mismatch;
         redirect_pc   <= mismatch ? actual_pc : 64'd0;
         upd_was_taken <= do_taken;
         upd_jumped    <= do_jump;
         upd_prev_pc   <= (do_taken || do_jump) ? head_pc   : 64'd0;
         upd_branch_pc <= (do_taken || do_jump) ? ex_target : 64'd0;
         if (underflow_evt) underflow <= 1'b1;
      end
   end

`ifdef BRU_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_resolved <= '0;
         stat_mispred  <= '0;
      end else begin
         if (pop && (stat_resolved != 32'hFFFF_FFFF))     stat_resolved <= stat_resolved + 32'd1;
         if (mismatch && (stat_mispred != 32'hFFFF_FFFF)) stat_mispred  <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-side counterpart of the branch target buffer. Records every fetched PC together with the BTB's predicted next PC in an in-order in-flight queue. When execute resolves an instruction, compares the actual next PC against that prediction, raises a one-cycle flush with the correct redirect PC on mismatch, and generates the BTB training write (`was_taken` / `jumped` / `prev_pc` / target).

## Interface
- `DEPTH`, 4: in-flight queue entries; power of two, 2..16.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `fetch_valid` input 1: a fetched instruction is offered this cycle.
- `fetch_ready` output 1: a queue slot is free and the unit is in RUN.
- `fetch_pc` input 64: PC of the fetched instruction.
- `fetch_pred_pc` input 64: BTB prediction; 0 means no prediction.
- `ex_valid` input 1: execute resolves the oldest in-flight instruction.
- `ex_is_branch` input 1: the instruction is a conditional branch.
- `ex_taken` input 1: the branch was taken; ignored unless `ex_is_branch`.
- `ex_is_jump` input 1: the instruction is an unconditional jump.
- `ex_target` input 64: resolved branch or jump target.
- `flush` output 1: one-cycle misprediction pulse.
- `redirect_pc` output 64: correct next PC; valid while `flush` is high.
- `upd_was_taken` output 1: BTB write, taken-branch form.
- `upd_jumped` output 1: BTB write, jump form.
- `upd_prev_pc` output 64: PC of the resolved instruction.
- `upd_branch_pc` output 64: target written to the BTB.
- `underflow` output 1: sticky error; `ex_valid` arrived while the queue was empty.
- `stat_resolved`, `stat_mispred` output 32 each: present only with `BRU_STATS_EN`.

## Operation
- Queue is a FIFO of {pc, pred_pc}, with read/write pointers of log2(DEPTH)+1 bits.
  - Push: `fetch_valid && fetch_ready`.
  - Pop: `ex_valid` with the queue non-empty.
- Full when the pointers differ only in the MSB.
  - `fetch_ready` = RUN && (!full || pop this cycle), so a simultaneous push and pop at full is allowed.
- Resolution, evaluated on the head entry (pc P, prediction Q) when `ex_valid`:
  - actual = (`ex_is_jump` || (`ex_is_branch` && `ex_taken`)) ? `ex_target` : P+4.
  - predicted = (Q != 0) ? Q : P+4.
  - All additions are 64-bit modulo 2^64.
  - Mismatch = actual != predicted.
- BTB update:
  - `upd_was_taken` = `ex_is_branch` && `ex_taken` && !`ex_is_jump`.
  - `upd_jumped` = `ex_is_jump`.
  - `upd_prev_pc` = P; `upd_branch_pc` = `ex_target`.
  - When both `ex_is_branch` and `ex_is_jump` are high, the instruction is treated as a jump.
  - No update for not-taken branches or non-control instructions.
- On mismatch:
  - `flush` = 1 and `redirect_pc` = actual.
  - The whole queue is cleared (pointers to 0); the push in that cycle is discarded.
  - FSM moves RUN -> DRAIN.
- FSM:
  - RUN: normal operation.
  - DRAIN: lasts exactly one cycle; `fetch_ready` = 0, `ex_valid` is ignored (no pop, no update, no flush), then returns to RUN.
- `ex_valid` on an empty queue in RUN: no pop, no update, no flush; `underflow` sets to 1 and is cleared only by `rst`.

## Timing
- Reset values: all outputs 0; queue empty; state RUN.
  - `fetch_ready` is 1 in the first cycle after `rst` deasserts.
- `flush`, `redirect_pc` and all `upd_*` outputs are registered: they appear in the cycle after the `ex_valid` edge and are held for exactly one cycle.
  - `upd_*` pulses even when a flush happens in the same cycle.
- `fetch_ready` is combinational from the state, the pointers and `ex_valid`.
- Queue state visible to a push is updated one cycle after the handshake; a push then pop of the same entry needs at least 1 cycle between them.
- `rst` mid-operation wins over all events, including a pending flush: queue cleared, FSM to RUN, registered pulses dropped.

## Configuration
- `BRU_STATS_EN` defined:
  - `stat_resolved` increments on every resolved pop.
  - `stat_mispred` increments on every mismatch.
  - Both saturate at 0xFFFF_FFFF; both are reset to 0 by `rst`.
- `BRU_STATS_EN` undefined: both ports and their counters are absent from the module.

## Test plan
- Correct taken prediction:
  - Push P=0x100, Q=0x200; then `ex_valid`, branch, taken, target 0x200.
  - Next cycle: `upd_was_taken`=1, `upd_prev_pc`=0x100, `upd_branch_pc`=0x200, `flush`=0.
- Unpredicted jump:
  - Push P=0x40, Q=0, then push 0x44; `ex_is_jump`, target 0x80.
  - Next cycle: `flush`=1, `redirect_pc`=0x80, `upd_jumped`=1; queue empty; `fetch_ready` low for 1 cycle, then high.
- False taken prediction:
  - P=0x10, Q=0x300; branch not taken.
  - `flush`=1, `redirect_pc`=0x14, no `upd_*` pulse.
- Full boundary:
  - DEPTH=4: push 4 entries and `fetch_ready` drops to 0.
  - Same cycle `ex_valid` (correct) plus `fetch_valid`: both accepted, occupancy stays 4.
- Underflow and reset:
  - `ex_valid` on an empty queue: `underflow`=1, no other outputs.
  - Assert `rst` during DRAIN: all outputs 0, `fetch_ready`=1 one cycle after deassert.
- Wrap-around:
  - P=0xFFFF_FFFF_FFFF_FFFC, Q=0, branch not taken: no flush.
  - With `BRU_STATS_EN`: `stat_resolved` counts 1, `stat_mispred` stays 0.
